// File: rtl/dual_port_memory_if.sv
// Bus bundle for the unified instruction/data memory: a fetch port, a data port
// and the init_done status flag.
interface dual_port_memory_if #(
  parameter int unsigned XLEN = 32
);
  logic            init_done;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_valid;
  logic            imem_fault;

  logic            dmem_req;
  logic            dmem_we;
  logic [1:0]      dmem_size;
  logic            dmem_unsigned;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_valid;
  logic            dmem_misalign;

  // Requester side (core / testbench).
  modport master (
    input  init_done,
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid, imem_fault,
    output dmem_req, dmem_we, dmem_size, dmem_unsigned, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_valid, dmem_misalign
  );

  // Memory side.
  modport slave (
    output init_done,
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid, imem_fault,
    input  dmem_req, dmem_we, dmem_size, dmem_unsigned, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_valid, dmem_misalign
  );
endinterface

// File: rtl/dual_port_memory.sv
// Unified instruction/data memory with an independent fetch port and a
// byte/half/word data port. Reads are registered and see pre-store contents.
// After reset the array is zero-filled before either port is serviced.
module dual_port_memory #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
) (
  input logic                clk,
  input logic                rst,
  dual_port_memory_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            init_done_q;

  logic [XLEN-1:0] mem [DEPTH];

  // Fetch port decode
  logic [AW-1:0] i_idx;
  logic          i_acc;
  logic          i_fault;

  assign i_idx   = bus.imem_addr[AW+1:2];
  assign i_acc   = init_done_q & bus.imem_req;
  assign i_fault = |bus.imem_addr[1:0];

  // Data port decode
  logic [AW-1:0]   d_idx;
  logic [1:0]      d_off;
  logic            d_acc;
  logic            d_mis;
  logic            d_store;
  logic            d_load;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_wsh;
  logic [XLEN-1:0] d_word;
  logic [7:0]      d_byte;
  logic [15:0]     d_half;
  logic [XLEN-1:0] d_ld;

  assign d_idx   = bus.dmem_addr[AW+1:2];
  assign d_off   = bus.dmem_addr[1:0];
  assign d_acc   = init_done_q & bus.dmem_req;
  assign d_store = d_acc & bus.dmem_we & ~d_mis;
  assign d_load  = d_acc & ~bus.dmem_we & ~d_mis;
  assign d_word  = mem[d_idx];

  // Address bits above the array size are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^{bus.imem_addr[XLEN-1:AW+2], bus.dmem_addr[XLEN-1:AW+2]};

  // Alignment check, byte strobes and lane-replicated store data
  always_comb begin
    d_mis = 1'b0;
    d_be  = 4'b0000;
    d_wsh = bus.dmem_wdata;
    unique case (bus.dmem_size)
      2'b00: begin
        d_be  = 4'b0001 << d_off;
        d_wsh = {4{bus.dmem_wdata[7:0]}};
      end
      2'b01: begin
        d_mis = d_off[0];
        d_be  = d_off[1] ? 4'b1100 : 4'b0011;
        d_wsh = {2{bus.dmem_wdata[15:0]}};
      end
      2'b10: begin
        d_mis = |d_off;
        d_be  = 4'b1111;
      end
      default: d_mis = 1'b1;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    d_byte = d_word[{d_off, 3'b000} +: 8];
    d_half = d_off[1] ? d_word[31:16] : d_word[15:0];
    d_ld   = '0;
    unique case (bus.dmem_size)
      2'b00:   d_ld = {{(XLEN-8){~bus.dmem_unsigned & d_byte[7]}}, d_byte};
      2'b01:   d_ld = {{(XLEN-16){~bus.dmem_unsigned & d_half[15]}}, d_half};
      2'b10:   d_ld = d_word;
      default: d_ld = '0;
    endcase
  end

  // Clear FSM: walks the array once after reset, then holds in run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: init_done_q <= 1'b1;
        default: begin
          state_q     <= StInit;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: zero-fill during init, lane-masked stores in run
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (d_store) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (d_be[b]) mem[d_idx][8*b +: 8] <= d_wsh[8*b +: 8];
      end
    end
  end

  // Registered responses; reads use the array value before this edge's store
  logic            imem_valid_q;
  logic            imem_fault_q;
  logic [XLEN-1:0] imem_rdata_q;
  logic            dmem_valid_q;
  logic            dmem_misalign_q;
  logic [XLEN-1:0] dmem_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_valid_q    <= 1'b0;
      imem_fault_q    <= 1'b0;
      imem_rdata_q    <= '0;
      dmem_valid_q    <= 1'b0;
      dmem_misalign_q <= 1'b0;
      dmem_rdata_q    <= '0;
    end else begin
      imem_valid_q    <= i_acc;
      imem_fault_q    <= i_acc & i_fault;
      imem_rdata_q    <= (i_acc & ~i_fault) ? mem[i_idx] : '0;
      dmem_valid_q    <= d_acc;
      dmem_misalign_q <= d_acc & d_mis;
      dmem_rdata_q    <= d_load ? d_ld : '0;
    end
  end

  assign bus.init_done     = init_done_q;
  assign bus.imem_valid    = imem_valid_q;
  assign bus.imem_fault    = imem_fault_q;
  assign bus.imem_rdata    = imem_rdata_q;
  assign bus.dmem_valid    = dmem_valid_q;
  assign bus.dmem_misalign = dmem_misalign_q;
  assign bus.dmem_rdata    = dmem_rdata_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: byte-addressed reference model checked every
// cycle, plus directed cases with literal expectations.
module tb_dual_port_memory;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned MAW   = AW + 2;
  localparam int unsigned MB    = DEPTH * 4;

  logic clk;
  logic rst;

  dual_port_memory_if #(.XLEN(32)) bus ();

  dual_port_memory #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat little-endian byte array
  logic [7:0] mb [MB];

  function automatic logic [31:0] model_read(input logic [MAW-1:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(mb[a + MAW'(k)]);
    return v;
  endfunction

  int unsigned cyc_since_rst;
  logic        e_done, e_iv, e_if, e_dv, e_dm;
  logic [31:0] e_ir, e_dr;

  // Per-cycle model update and comparison
  initial begin : compare
    logic            ready;
    logic [MAW-1:0]  ia, da;
    logic [1:0]      sz;
    logic            mis;
    int              n;
    logic [31:0]     v;
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc_since_rst = 0;
        for (int i = 0; i < int'(MB); i++) mb[i] = 8'h00;
        continue;
      end
      ready = (cyc_since_rst >= DEPTH);
      // fetch port
      ia   = bus.imem_addr[MAW-1:0];
      e_iv = ready && bus.imem_req;
      e_if = e_iv && (ia % 4 != 0);
      e_ir = (e_iv && !e_if) ? model_read(ia, 4) : 32'h0;
      // data port
      da   = bus.dmem_addr[MAW-1:0];
      sz   = bus.dmem_size;
      mis  = (sz == 2'b11) || (sz == 2'b01 && da % 2 != 0) || (sz == 2'b10 && da % 4 != 0);
      n    = 1 << sz;
      e_dv = ready && bus.dmem_req;
      e_dm = e_dv && mis;
      e_dr = 32'h0;
      if (e_dv && !mis && !bus.dmem_we) begin
        v = model_read(da, n);
        if (!bus.dmem_unsigned && n == 1 && v >= 32'd128)   v = v - 32'd256;
        if (!bus.dmem_unsigned && n == 2 && v >= 32'd32768) v = v - 32'd65536;
        e_dr = v;
      end
      if (e_dv && !mis && bus.dmem_we) begin
        for (int k = 0; k < n; k++) mb[da + MAW'(k)] = bus.dmem_wdata[8*k +: 8];
      end
      if (cyc_since_rst < DEPTH) cyc_since_rst++;
      e_done = (cyc_since_rst >= DEPTH);
      #1;
      if (!rst) begin
        check("init_done", 32'(bus.init_done), 32'(e_done));
        check("imem_valid", 32'(bus.imem_valid), 32'(e_iv));
        check("imem_fault", 32'(bus.imem_fault), 32'(e_if));
        check("dmem_valid", 32'(bus.dmem_valid), 32'(e_dv));
        if (e_iv) check("imem_rdata", bus.imem_rdata, e_ir);
        if (e_dv) begin
          check("dmem_misalign", 32'(bus.dmem_misalign), 32'(e_dm));
          check("dmem_rdata", bus.dmem_rdata, e_dr);
        end
      end
    end
  end

  task automatic idle();
    bus.imem_req      = 1'b0;
    bus.imem_addr     = '0;
    bus.dmem_req      = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.dmem_size     = 2'b00;
    bus.dmem_unsigned = 1'b0;
    bus.dmem_addr     = '0;
    bus.dmem_wdata    = '0;
  endtask

  task automatic data_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic mis);
    @(negedge clk);
    bus.dmem_req = 1'b1; bus.dmem_we = we; bus.dmem_size = size;
    bus.dmem_unsigned = uns; bus.dmem_addr = addr; bus.dmem_wdata = wdata;
    @(posedge clk); #2;
    rd  = bus.dmem_rdata;
    mis = bus.dmem_misalign;
    check("dmem_valid_pulse", 32'(bus.dmem_valid), 32'd1);
    bus.dmem_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] rd, output logic flt);
    @(negedge clk);
    bus.imem_req = 1'b1; bus.imem_addr = addr;
    @(posedge clk); #2;
    rd  = bus.imem_rdata;
    flt = bus.imem_fault;
    bus.imem_req = 1'b0;
  endtask

  task automatic wait_init(output int n, output int iv_seen);
    n = 0; iv_seen = 0;
    while (!bus.init_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (bus.imem_valid && !bus.init_done) iv_seen++;
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic        mis;
    int          n, iv_seen;
    logic [31:0] a;

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset sequencing with fetches held on throughout init
    bus.imem_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init(n, iv_seen);
    check("init_cycles", 32'(n), 32'd1024);
    check("init_no_ivalid", 32'(iv_seen), 32'd0);
    bus.imem_req = 1'b0;

    for (int i = 0; i < 4; i++) begin
      a = $urandom() & 32'hFFFF_FFFC;
      fetch(a, rd, mis);
      check("fetch_zero", rd, 32'h0);
    end

    // Store/load widths
    data_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rd, mis);
    check("store_rdata", rd, 32'h0);
    data_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, mis); check("lb_10", rd, 32'h00000001);
    data_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, mis); check("lb_11", rd, 32'h0000007F);
    data_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, rd, mis); check("lb_12", rd, 32'hFFFFFFFF);
    data_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, mis); check("lb_13", rd, 32'hFFFFFF80);
    data_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, rd, mis); check("lbu_12", rd, 32'h000000FF);
    data_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, mis); check("lh_12", rd, 32'hFFFF80FF);
    data_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, mis); check("lhu_10", rd, 32'h00007F01);

    // Partial store
    data_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, rd, mis);
    data_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis); check("lw_10_sb", rd, 32'h80FFAB01);

    // Misalign
    data_op(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF, rd, mis);
    check("sh_21_mis", 32'(mis), 32'd1); check("sh_21_rd", rd, 32'h0);
    data_op(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, mis);
    check("lw_22_mis", 32'(mis), 32'd1); check("lw_22_rd", rd, 32'h0);
    data_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, mis);
    check("sz11_mis", 32'(mis), 32'd1); check("sz11_rd", rd, 32'h0);
    data_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis);
    check("lw_20_unch", rd, 32'h0); check("lw_20_nomis", 32'(mis), 32'd0);
    fetch(32'h02, rd, mis);
    check("fetch_02_fault", 32'(mis), 32'd1); check("fetch_02_rd", rd, 32'h0);

    // Same-word conflict: fetch sees old contents
    @(negedge clk);
    bus.imem_req = 1'b1; bus.imem_addr = 32'h40;
    bus.dmem_req = 1'b1; bus.dmem_we = 1'b1; bus.dmem_size = 2'b10;
    bus.dmem_addr = 32'h40; bus.dmem_wdata = 32'h12345678;
    @(posedge clk); #2;
    check("conflict_old", bus.imem_rdata, 32'h0);
    idle();
    fetch(32'h40, rd, mis); check("conflict_new", rd, 32'h12345678);
    data_op(1'b0, 2'b10, 1'b0, 32'h1040, 32'h0, rd, mis); check("wrap_1040", rd, 32'h12345678);

    // Random traffic on both ports, dense addresses to provoke conflicts
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.imem_req  = ($urandom() % 4) != 0;
      bus.imem_addr = ($urandom() & ~32'(MB - 1)) | 32'($urandom_range(0, 63) & 32'h3C)
                      | (($urandom() % 8 == 0) ? 32'd2 : 32'd0);
      bus.dmem_req      = ($urandom() % 4) != 0;
      bus.dmem_we       = $urandom() % 2;
      bus.dmem_size     = ($urandom() % 10 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.dmem_unsigned = $urandom() % 2;
      bus.dmem_addr     = ($urandom() & ~32'(MB - 1)) | 32'($urandom_range(0, 63));
      bus.dmem_wdata    = $urandom();
    end
    @(negedge clk);
    idle();

    // Reset mid-stream during continuous fetches
    data_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, rd, mis);
    bus.imem_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.imem_addr = $urandom() & 32'hFFFF_FFFC;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_ivalid", 32'(bus.imem_valid), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    wait_init(n, iv_seen);
    check("reinit_ok", 32'(bus.init_done), 32'd1);
    check("reinit_no_ivalid", 32'(iv_seen), 32'd0);
    bus.imem_req = 1'b0;
    data_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis); check("reinit_10", rd, 32'h0);
    data_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, mis); check("reinit_40", rd, 32'h0);
    fetch(32'h1010, rd, mis); check("reinit_fetch", rd, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_port_memory.md
Name: dual_port_memory

Overview:
Parametrised unified instruction/data memory for the RISC-V core, replacing the single-bank flat memory. It has an independent instruction-fetch port and a data port. The data port supports byte/half/word loads and stores with sign or zero extension, and reads are registered. After reset, a clear state machine zero-fills the array before either port accepts requests.

Parameters:
XLEN, 32, data/address width in bits (32 only in this revision).
DEPTH, 1024, number of XLEN-bit words; power of two, ≥4.
AW, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
init_done  output  1  high once zero-fill is complete; both ports are ready
imem_req  input  1  instruction fetch request
imem_addr  input  XLEN  byte address of the fetch
imem_rdata  output  XLEN  fetched word
imem_valid  output  1  one-cycle pulse: imem_rdata/imem_fault valid
imem_fault  output  1  fetch address not word-aligned
dmem_req  input  1  data access request
dmem_we  input  1  1 = store, 0 = load
dmem_size  input  2  00 byte, 01 half, 10 word, 11 illegal
dmem_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
dmem_addr  input  XLEN  byte address of the access
dmem_wdata  input  XLEN  store data, right-aligned
dmem_rdata  output  XLEN  extended load result
dmem_valid  output  1  one-cycle pulse: access completed
dmem_misalign  output  1  qualified by dmem_valid: access rejected

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM → INIT; clear counter → 0. Array contents are not reset directly; they are zero-filled by INIT.
- FSM INIT: each cycle, write 0 to mem[cnt] and increment cnt. When cnt==DEPTH-1 is written, go to RUN next cycle. INIT lasts exactly DEPTH cycles after reset release.
- FSM RUN: init_done=1; stays in RUN until rst.
- Requests while init_done=0 are ignored: no valid pulse, no write.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Fetch:
  - imem_req in cycle N → imem_valid=1 in N+1 with imem_rdata = mem[index].
  - If imem_addr[1:0]≠0: imem_fault=1 and imem_rdata=0.
  - Back-to-back requests give back-to-back valids.
- Load:
  - dmem_req & !dmem_we in cycle N → dmem_valid in N+1.
  - Lane is selected by addr[1:0] (byte) or addr[1] (half).
  - Result is sign- or zero-extended to XLEN per dmem_unsigned; word loads ignore dmem_unsigned.
- Store:
  - dmem_req & dmem_we in cycle N → the selected byte lanes are written at the N rising edge.
  - Strobes: byte → 1 lane; half → lanes {addr[1],0}..+1; word → all 4.
  - Store data is taken from the low bytes of dmem_wdata.
  - dmem_valid=1 in N+1 with dmem_rdata=0.
- Misalign:
  - Condition: half with addr[0]=1; word with addr[1:0]≠0; or size=11.
  - Required response: no write, dmem_valid=1 and dmem_misalign=1 in N+1, dmem_rdata=0.
- Same-word conflict: fetch or load in the same cycle as a store to that word returns the OLD contents (read-before-write). An access in the following cycle sees the new data.
- Both ports may be active every cycle; there are no stalls and no backpressure in RUN.
- Flags: valid, fault and misalign are single-cycle; they drop to 0 the cycle after unless a new request occurs.
- Reset mid-operation: in-flight valids are cleared immediately; the FSM restarts INIT and the array is zero-filled again.

Test Plan:
- Reset sequencing:
  - Stimulus: assert rst, release; drive imem_req=1 throughout INIT.
  - Response: init_done rises exactly 1024 cycles after release; no imem_valid during INIT.
  - Stimulus: after init_done, fetch from random addresses.
  - Response: 0x00000000 returned.
- Store/load widths:
  - Stimulus: store word 0x80FF7F01 at 0x10.
  - Response, loads at 0x10..0x13 (signed bytes): 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Load byte unsigned at 0x12: 0x000000FF. Load half signed at 0x12: 0xFFFF80FF. Load half unsigned at 0x10: 0x00007F01.
- Partial store:
  - Stimulus: store byte 0xAB at 0x11 over 0x80FF7F01.
  - Response: word load at 0x10 returns 0x80FFAB01.
- Misalign:
  - Stimulus: store half at 0x21; then load word at 0x22; then size=11.
  - Response: each gives dmem_valid=1, dmem_misalign=1, dmem_rdata=0. Word at 0x20 is unchanged. imem fetch at 0x02 gives imem_fault=1.
- Conflict and wrap:
  - Stimulus: same cycle, fetch 0x40 and store word 0x12345678 at 0x40 (old value 0).
  - Response: imem_rdata=0; the next fetch returns 0x12345678.
  - Stimulus: load from 0x1040 (DEPTH=1024).
  - Response: 0x12345678 (address wraps).
- Reset mid-stream:
  - Stimulus: pulse rst for one cycle during continuous fetches.
  - Response: imem_valid drops in the same cycle and init_done=0. After re-INIT, all previously written words read 0.
